// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the modular-multiplier stream host.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mm_pkg;

  localparam int MM_CAL_WIDTH      = 256;
  localparam int MM_IO_WIDTH       = 32;
  localparam int MM_BEATS          = MM_CAL_WIDTH / MM_IO_WIDTH;
  localparam int MM_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  // One extra bit over clog2(beats) so the counter can never wrap inside a
  // transaction.
  function automatic int cnt_width(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/mm_word_shifter.sv
// Parallel-load / serial-shift register with a beat counter, LANES lanes wide.
// Latency: load or shift takes effect on the next clk edge; o_top is the registered top word.
// Backpressure: none internally; the caller gates i_shift with its own handshake.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears data and count)
//   i_load           load i_load_dat into all lanes and clear the counter (wins over i_shift)
//   i_load_dat       lane k occupies bits [k*W +: W]
//   i_shift          shift every lane left by IO bits, filling LSBs from i_shift_dat
//   i_shift_dat      lane k fill word at bits [k*IO +: IO]
//   o_dat            current register contents
//   o_top            top IO bits of every lane (lane k at [k*IO +: IO])
//   o_cnt            number of shifts since the last load
module mm_word_shifter
  import mm_pkg::*;
#(
  parameter int W     = MM_CAL_WIDTH,
  parameter int IO    = MM_IO_WIDTH,
  parameter int LANES = 1,
  parameter int CNT_W = cnt_width(MM_BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [LANES*W-1:0]    i_load_dat,
  input  logic                  i_shift,
  input  logic [LANES*IO-1:0]   i_shift_dat,
  output logic [LANES*W-1:0]    o_dat,
  output logic [LANES*IO-1:0]   o_top,
  output logic [CNT_W-1:0]      o_cnt
);

  logic [LANES*W-1:0] r_dat;
  logic [CNT_W-1:0]   r_cnt;
  logic [LANES*W-1:0] w_nxt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    // Lanes shift independently so the operand words never bleed into each other.
    assign w_nxt[k*W +: W]  = {r_dat[k*W +: W-IO], i_shift_dat[k*IO +: IO]};
    assign o_top[k*IO +: IO] = r_dat[k*W + W - IO +: IO];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_dat <= i_load_dat;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_dat <= w_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_dat = r_dat;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/mod_mult_stream_host.sv
// Initiator-side adapter: serializes a 256-bit operand pair into MSB-first 32-bit
// beats for the streaming modular multiplier and reassembles the 8 result beats.
// Latency: 1 accept + 8 send + multiplier + 8 receive + 1 to rsp_valid; backpressure via
// req_ready (idle only), mm_in_ready stalls send, rsp_ready holds the result.
//
// Optional feature macro: MM_TIMEOUT_EN (RECV watchdog; forces DONE with rsp_err=1).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready/req_a/req_b   operand-pair request (ready only when idle)
//   mm_in_valid/mm_in_ready           beat channel toward the multiplier
//   mm_num1/mm_num2                   A/B beat, most significant word first
//   mm_out_valid/mm_out_ready/mm_res  result beat channel from the multiplier
//   rsp_valid/rsp_ready/rsp_res       assembled result toward the controller
//   rsp_err                           watchdog timeout flag (0 unless MM_TIMEOUT_EN)
module mod_mult_stream_host
  import mm_pkg::*;
#(
  parameter int CAL_WIDTH      = MM_CAL_WIDTH,
  parameter int IO_WIDTH       = MM_IO_WIDTH,
  parameter int TIMEOUT_CYCLES = MM_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CAL_WIDTH-1:0] req_a,
  input  logic [CAL_WIDTH-1:0] req_b,
  output logic                 mm_in_valid,
  input  logic                 mm_in_ready,
  output logic [IO_WIDTH-1:0]  mm_num1,
  output logic [IO_WIDTH-1:0]  mm_num2,
  input  logic                 mm_out_valid,
  output logic                 mm_out_ready,
  input  logic [IO_WIDTH-1:0]  mm_res,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CAL_WIDTH-1:0] rsp_res,
  output logic                 rsp_err
);

  // CAL_WIDTH must be a multiple of IO_WIDTH with at least two beats.
  localparam int BEATS = CAL_WIDTH / IO_WIDTH;
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t r_state;
  logic   r_req_ready;
  logic   r_mm_in_valid;
  logic   r_mm_out_ready;
  logic   r_rsp_valid;

  logic                   w_accept;
  logic                   w_tx_fire;
  logic                   w_rx_fire;
  logic                   w_rsp_fire;
  logic                   w_timeout;
  logic [CNT_W-1:0]       w_tx_cnt;
  logic [CNT_W-1:0]       w_rx_cnt;
  logic [2*IO_WIDTH-1:0]  w_tx_top;
  logic [CAL_WIDTH-1:0]   w_rx_dat;
  logic [2*CAL_WIDTH-1:0] w_tx_dat_unused;
  logic [IO_WIDTH-1:0]    w_rx_top_unused;

  assign w_accept   = req_valid && r_req_ready;
  assign w_tx_fire  = r_mm_in_valid && mm_in_ready;
  assign w_rx_fire  = r_mm_out_ready && mm_out_valid;
  assign w_rsp_fire = r_rsp_valid && rsp_ready;

  // TX pair: lane 0 = A, lane 1 = B, both shifted on each accepted beat.
  mm_word_shifter #(
    .W     (CAL_WIDTH),
    .IO    (IO_WIDTH),
    .LANES (2),
    .CNT_W (CNT_W)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_dat  ({req_b, req_a}),
    .i_shift     (w_tx_fire),
    .i_shift_dat ('0),
    .o_dat       (w_tx_dat_unused),
    .o_top       (w_tx_top),
    .o_cnt       (w_tx_cnt)
  );

  // RX accumulator: beats enter at the LSB end so the first beat ends up on top.
  // It stops shifting once RECV ends, so it doubles as the response register.
  mm_word_shifter #(
    .W     (CAL_WIDTH),
    .IO    (IO_WIDTH),
    .LANES (1),
    .CNT_W (CNT_W)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_dat  ('0),
    .i_shift     (w_rx_fire),
    .i_shift_dat (mm_res),
    .o_dat       (w_rx_dat),
    .o_top       (w_rx_top_unused),
    .o_cnt       (w_rx_cnt)
  );

`ifdef MM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_rsp_err;

  // Fires on the TIMEOUT_CYCLES-th consecutive beat-less cycle in RECV.
  assign w_timeout = (r_state == RECV) && !w_rx_fire && (r_wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state != RECV || w_rx_fire) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end else if (w_rsp_fire) begin
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign rsp_err = r_rsp_err;
`else
  logic w_cfg_unused;
  assign w_cfg_unused = |TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_req_ready    <= 1'b1;
      r_mm_in_valid  <= 1'b0;
      r_mm_out_ready <= 1'b0;
      r_rsp_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready   <= 1'b0;
            r_mm_in_valid <= 1'b1;
            r_state       <= SEND;
          end
        end
        SEND: begin
          if (w_tx_fire && (w_tx_cnt == LAST_BEAT)) begin
            r_mm_in_valid  <= 1'b0;
            r_mm_out_ready <= 1'b1;
            r_state        <= RECV;
          end
        end
        RECV: begin
          // The multiplier streams its burst unthrottled, so ready stays high
          // for the whole of RECV.
          if ((w_rx_fire && (w_rx_cnt == LAST_BEAT)) || w_timeout) begin
            r_mm_out_ready <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_state        <= DONE;
          end
        end
        DONE: begin
          // req_ready only rises on leaving DONE, so a request presented
          // alongside rsp_ready is taken one cycle later in IDLE.
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign mm_in_valid  = r_mm_in_valid;
  assign mm_out_ready = r_mm_out_ready;
  assign rsp_valid    = r_rsp_valid;
  assign mm_num1      = w_tx_top[IO_WIDTH-1:0];
  assign mm_num2      = w_tx_top[2*IO_WIDTH-1:IO_WIDTH];
  assign rsp_res      = w_rx_dat;

endmodule

// File: tb/tb_mod_mult_stream_host.sv
// Directed bench for mod_mult_stream_host: serialization order, stalls, result
// assembly, response hold, mid-transaction reset, and the RECV watchdog (or its absence).
// Inputs change 1ns after posedge; outputs are sampled at the same point.
module tb_mod_mult_stream_host;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         mm_in_valid;
  logic         mm_in_ready;
  logic [31:0]  mm_num1;
  logic [31:0]  mm_num2;
  logic         mm_out_valid;
  logic         mm_out_ready;
  logic [31:0]  mm_res;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_res;
  logic         rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  mod_mult_stream_host dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .mm_in_valid  (mm_in_valid),
    .mm_in_ready  (mm_in_ready),
    .mm_num1      (mm_num1),
    .mm_num2      (mm_num2),
    .mm_out_valid (mm_out_valid),
    .mm_out_ready (mm_out_ready),
    .mm_res       (mm_res),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  256'(req_ready),    256'd1);
    check({tag, "_in_valid"},   256'(mm_in_valid),  256'd0);
    check({tag, "_out_ready"},  256'(mm_out_ready), 256'd0);
    check({tag, "_rsp_valid"},  256'(rsp_valid),    256'd0);
    check({tag, "_rsp_err"},    256'(rsp_err),      256'd0);
    check({tag, "_num1"},       256'(mm_num1),      256'd0);
    check({tag, "_num2"},       256'(mm_num2),      256'd0);
    check({tag, "_rsp_res"},    rsp_res,            256'd0);
  endtask

  task automatic do_req(input logic [255:0] a, input logic [255:0] b);
    int c = 0;
    while (!req_ready && c < 50) begin
      tick();
      c++;
    end
    check("req_ready_wait", 256'(req_ready), 256'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    check("accept_in_valid",  256'(mm_in_valid), 256'd1);
    check("accept_req_ready", 256'(req_ready),   256'd0);
  endtask

  // Presents all beats; toggle stalls every other cycle, junk drives stray result beats.
  task automatic send_beats(input logic [255:0] a, input logic [255:0] b, input bit toggle, input bit junk);
    int got = 0;
    int cyc = 0;
    mm_out_valid = junk;
    mm_res       = 32'hDEADBEEF;
    while (got < 8 && cyc < 64) begin
      mm_in_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      check("send_in_valid",  256'(mm_in_valid),  256'd1);
      check("send_num1",      256'(mm_num1),      256'(a[255-32*got -: 32]));
      check("send_num2",      256'(mm_num2),      256'(b[255-32*got -: 32]));
      check("send_out_ready", 256'(mm_out_ready), 256'd0);
      if (mm_in_ready) got++;
      tick();
      cyc++;
    end
    mm_out_valid = 1'b0;
    mm_in_ready  = 1'b1;
    check("send_beat_count", 256'(got),          256'd8);
    check("send_end_valid",  256'(mm_in_valid),  256'd0);
    check("send_end_ready",  256'(mm_out_ready), 256'd1);
  endtask

  task automatic recv_beats(input logic [255:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      check("recv_out_ready", 256'(mm_out_ready), 256'd1);
      check("recv_rsp_valid", 256'(rsp_valid),    256'd0);
      mm_out_valid = 1'b1;
      mm_res       = w[255-32*i -: 32];
      tick();
    end
    mm_out_valid = 1'b0;
  endtask

  task automatic check_done(input logic [255:0] exp_res);
    check("done_rsp_valid", 256'(rsp_valid),    256'd1);
    check("done_rsp_res",   rsp_res,            exp_res);
    check("done_rsp_err",   256'(rsp_err),      256'd0);
    check("done_out_ready", 256'(mm_out_ready), 256'd0);
    check("done_req_ready", 256'(req_ready),    256'd0);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hs_rsp_valid", 256'(rsp_valid), 256'd0);
    check("hs_req_ready", 256'(req_ready), 256'd1);
  endtask

  logic [255:0] a2, b2, res2, a4, b4, a5, b5, res5, res6;

  initial begin
    a2   = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
    b2   = 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_FEDCBA98_76543210_0BADF00D_5A5A5A5A;
    res2 = 256'hFFFFFFFF_00000000_00000000_00000000_00000000_00000000_00000000_A5A5A5A5;
    a4   = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    b4   = 256'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF_00000000;
    a5   = 256'hCAFEBABE_00000000_FFFFFFFF_12345678_00000001_80000000_7FFFFFFF_AAAA5555;
    b5   = 256'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00_13579BDF_2468ACE0_FFFF0000_0000FFFF;
    res5 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    res6 = 256'hAAAA0001_BBBB0002_CCCC0003_DDDD0004_EEEE0005_FFFF0006_12340007_56780008;

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_a        = '0;
    req_b        = '0;
    mm_in_ready  = 1'b1;
    mm_out_valid = 1'b0;
    mm_res       = '0;
    rsp_ready    = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Stray result beat while idle must be refused.
    mm_out_valid = 1'b1;
    mm_res       = 32'h12345678;
    tick();
    check("idle_out_ready", 256'(mm_out_ready), 256'd0);
    mm_out_valid = 1'b0;

    // a = b = 1: only the last beat is non-zero; result 1.
    do_req(256'h1, 256'h1);
    send_beats(256'h1, 256'h1, 1'b0, 1'b0);
    recv_beats(256'h1, 0, 8);
    check_done(256'h1);
    handshake();

    // Counting words with stalls and stray result beats during SEND.
    do_req(a2, b2);
    send_beats(a2, b2, 1'b1, 1'b1);
    recv_beats(res2, 0, 8);
    check_done(res2);

    // Hold the response for 10 cycles with a new request already waiting.
    req_valid = 1'b1;
    req_a     = a4;
    req_b     = b4;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_rsp_valid", 256'(rsp_valid),   256'd1);
      check("hold_rsp_res",   rsp_res,           res2);
      check("hold_req_ready", 256'(req_ready),   256'd0);
      check("hold_in_valid",  256'(mm_in_valid), 256'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hs2_rsp_valid", 256'(rsp_valid),   256'd0);
    check("hs2_req_ready", 256'(req_ready),   256'd1);
    check("hs2_in_valid",  256'(mm_in_valid), 256'd0);
    tick();
    req_valid = 1'b0;
    check("next_in_valid",  256'(mm_in_valid), 256'd1);
    check("next_req_ready", 256'(req_ready),   256'd0);
    check("next_num1",      256'(mm_num1),     256'h11111111);

    // Reset while beat 4 is on the bus.
    mm_in_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("beat4_num1", 256'(mm_num1), 256'h55555555);
    check("beat4_num2", 256'(mm_num2), 256'hDDDDDDDD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");

    // Full transaction after the abort.
    do_req(a5, b5);
    send_beats(a5, b5, 1'b0, 1'b0);
    recv_beats(res5, 0, 8);
    check_done(res5);
    handshake();

    // Multiplier goes silent after 3 result beats.
    do_req(a2, b2);
    send_beats(a2, b2, 1'b0, 1'b0);
    recv_beats(res6, 0, 3);
`ifdef MM_TIMEOUT_EN
    for (int i = 0; i < 63; i++) tick();
    check("wd_before_valid", 256'(rsp_valid), 256'd0);
    check("wd_before_err",   256'(rsp_err),   256'd0);
    tick();
    check("wd_rsp_valid", 256'(rsp_valid),    256'd1);
    check("wd_rsp_err",   256'(rsp_err),      256'd1);
    check("wd_rsp_res",   rsp_res,            256'h00000000_00000000_00000000_00000000_00000000_AAAA0001_BBBB0002_CCCC0003);
    check("wd_out_ready", 256'(mm_out_ready), 256'd0);
    handshake();
    check("wd_err_clear", 256'(rsp_err), 256'd0);
`else
    for (int i = 0; i < 100; i++) tick();
    check("wait_rsp_valid", 256'(rsp_valid),    256'd0);
    check("wait_rsp_err",   256'(rsp_err),      256'd0);
    check("wait_out_ready", 256'(mm_out_ready), 256'd1);
    recv_beats(res6, 3, 5);
    check_done(res6);
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_mult_stream_host.md
Name: mod_mult_stream_host

Overview:
- Initiator-side adapter for the 32-bit streaming modular multiplier.
- Accepts a 256-bit operand pair from the SM2 point-arithmetic controller and serializes it into 8 beats of num1/num2, MSB word first.
- Collects the 8 result beats back into one 256-bit word and returns it to the controller on a valid/ready response channel.
- One transaction in flight at a time.

Parameters:
- CAL_WIDTH, 256, operand/result width.
- IO_WIDTH, 32, beat width.
- BEATS, CAL_WIDTH/IO_WIDTH (8), beats per operand/result; CAL_WIDTH must be a multiple of IO_WIDTH.
- TIMEOUT_CYCLES, 64, RECV watchdog limit (used only with the optional feature).

Ports:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  operand pair valid.
- req_ready  out  1  block idle; can accept a request.
- req_a  in  CAL_WIDTH  operand A.
- req_b  in  CAL_WIDTH  operand B.
- mm_in_valid  out  1  beat valid toward multiplier.
- mm_in_ready  in  1  multiplier accepts beat.
- mm_num1  out  IO_WIDTH  A beat.
- mm_num2  out  IO_WIDTH  B beat.
- mm_out_valid  in  1  result beat valid from multiplier.
- mm_out_ready  out  1  host ready for result beats.
- mm_res  in  IO_WIDTH  result beat.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  controller consumes result.
- rsp_res  out  CAL_WIDTH  assembled result.
- rsp_err  out  1  timeout flag (only with MM_TIMEOUT_EN; tied 0 otherwise).

Behaviour:
- Reset values: req_ready=1, mm_in_valid=0, mm_out_ready=0, rsp_valid=0, rsp_err=0, mm_num1=mm_num2=0, rsp_res=0, beat counters=0, state=IDLE. Reset mid-transaction aborts and discards all partial data.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_a/req_b into shift registers, clear counters, go to SEND.
- SEND:
  - mm_in_valid=1; mm_num1/mm_num2 = current top word of the shift registers. Beat 0 = bits [255:224].
  - A beat transfers on mm_in_valid&&mm_in_ready. Then shift left by IO_WIDTH and increment send_cnt.
  - If mm_in_ready is low, data holds stable.
  - After the transfer with send_cnt==BEATS-1: deassert mm_in_valid the next cycle and go to RECV.
- RECV:
  - mm_out_ready=1 continuously; the multiplier needs ready held for the whole burst.
  - Each mm_out_valid&&mm_out_ready beat is shifted into the LSB side of the accumulator; recv_cnt increments.
  - The first beat received ends as bits [255:224].
  - After beat BEATS-1: load rsp_res, drop mm_out_ready, go to DONE.
  - mm_out_valid arriving in SEND or IDLE is ignored; mm_out_ready=0 there.
- DONE:
  - rsp_valid=1, rsp_res stable until rsp_valid&&rsp_ready, then go to IDLE.
  - Simultaneous rsp_ready and a new req_valid: the request is not accepted that cycle (req_ready=0 in DONE). It is accepted in IDLE on the next cycle.
- Latency:
  - 1 cycle accept.
  - + 8 send cycles (ready always high).
  - + multiplier latency.
  - + 8 receive cycles.
  - + 1 cycle to rsp_valid.
- Arithmetic: none; pure width conversion. Counters are clog2(BEATS)+1 bits and never wrap within a transaction.

Optional Feature:
- Macro: MM_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in RECV without a beat.
  - Reaching TIMEOUT_CYCLES forces DONE with rsp_err=1 and rsp_res = partial accumulator.
  - rsp_err clears on the response handshake.
- Undefined: no watchdog; rsp_err is constant 0; RECV waits indefinitely.

Decomposition:
- Shared package mm_pkg:
  - CAL_WIDTH, IO_WIDTH, BEATS constants.
  - state enum IDLE/SEND/RECV/DONE.
- One natural sub-module, mm_word_shifter: a parallel-load/serial-shift register with a beat counter. Instantiated for the TX pair and the RX accumulator.

Test Plan:
- a=b=256'h1 with mm_in_ready=1 → beats 0–6 carry 0, beat 7 carries 32'h1 on both num1/num2. Result beats 0..7 = 0,...,0,32'h1 → rsp_res=256'h1.
- a=256'h0001_0002_..._0008 (word i=i+1), mm_in_ready toggling 1/0 → num1 sequence 1..8 with no duplicates or drops; data stable while stalled.
- Result beats 32'hFFFFFFFF,0,...,0,32'hA5A5A5A5 → rsp_res = {32'hFFFFFFFF,192'h0,32'hA5A5A5A5}.
- rsp_ready held low 10 cycles → rsp_valid and rsp_res stable; req_ready=0 throughout; new req accepted one cycle after the handshake.
- rst pulsed at send beat 4 → all outputs at reset values next cycle; a following full transaction completes correctly.
- MM_TIMEOUT_EN, multiplier silent after 3 result beats → rsp_valid with rsp_err=1 after TIMEOUT_CYCLES (64) idle cycles.
